// File: rtl/alu_mdu_iter.sv
// Execute-stage ALU with valid/ready handshakes and iterative RV M-extension multiply/divide.
// Single-cycle ops and divide early-outs finish in one cycle; MUL*/DIV* take XLEN iterations plus a sign fixup.
module alu_mdu_iter #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [4:0]      op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] md_q, md_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;

    logic            accept;
    logic            isIter, isDiv, divZero, divOvf, earlyOut;
    logic            aSgn, bSgn;
    logic [XLEN-1:0] aMag, bMag;
    logic [XLEN-1:0] aluRes, earlyRes, singleRes;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN:0]   mulSum;
    logic [XLEN:0]   divTmp;
    logic            divGe;
    logic [XLEN-1:0] divDiff;
    logic [2*XLEN-1:0] prod, prodFix;
    logic [XLEN-1:0] quoFix, remFix, fixRes;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;

    assign shamt = b[SHAMT_W-1:0];

    always_comb begin
        aluRes = '0;
        case (op)
            5'b00010: aluRes = a + b;
            5'b00110: aluRes = a - b;
            5'b00000: aluRes = a & b;
            5'b00001: aluRes = a | b;
            5'b00011: aluRes = a ^ b;
            5'b00100: aluRes = a << shamt;
            5'b00101: aluRes = a >> shamt;
            5'b00111: aluRes = $unsigned($signed(a) >>> shamt);
            5'b01000: aluRes = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            5'b01001: aluRes = {{(XLEN-1){1'b0}}, (a < b)};
            5'b01010: aluRes = b;
            default:  aluRes = '0;
        endcase
    end

    // Divide-by-zero and signed overflow bypass the iterative datapath entirely.
    assign isIter   = op[4] & ~op[3];
    assign isDiv    = isIter & op[2];
    assign divZero  = (b == '0);
    assign divOvf   = ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    assign earlyOut = isDiv & (divZero | divOvf);
    assign earlyRes = divZero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    assign singleRes = earlyOut ? earlyRes : aluRes;

    assign aSgn = a[XLEN-1] & (op[2] ? ~op[0] : (op[1] ^ op[0]));
    assign bSgn = b[XLEN-1] & (op[2] ? ~op[0] : (op[1:0] == 2'b01));
    assign aMag = aSgn ? -a : a;
    assign bMag = bSgn ? -b : b;

    assign mulSum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? md_q : '0)};
    assign divTmp  = {hi_q, lo_q[XLEN-1]};
    assign divGe   = (divTmp >= {1'b0, md_q});
    assign divDiff = divTmp[XLEN-1:0] - md_q;

    always_comb begin
        prod    = {hi_q, lo_q};
        prodFix = neg_q ? -prod : prod;
        quoFix  = neg_q ? -lo_q : lo_q;
        remFix  = rneg_q ? -hi_q : hi_q;
        if (op_q[2]) begin
            fixRes = op_q[1] ? remFix : quoFix;
        end else begin
            fixRes = (op_q[1:0] == 2'b00) ? prodFix[XLEN-1:0] : prodFix[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        md_d     = md_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                BUSY: begin
                    if (cnt_q == LAST_CNT) begin
                        result_d = fixRes;
                        zero_d   = (fixRes == '0);
                        state_d  = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (op_q[2]) begin
                            hi_d = divGe ? divDiff : divTmp[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], divGe};
                        end else begin
                            hi_d = mulSum[XLEN:1];
                            lo_d = {mulSum[0], lo_q[XLEN-1:1]};
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
            // Dividend/multiplier sits in lo so both algorithms shift through the same pair.
            if (accept) begin
                op_d   = op;
                cnt_d  = '0;
                hi_d   = '0;
                neg_d  = aSgn ^ bSgn;
                rneg_d = aSgn;
                if (isIter & ~earlyOut) begin
                    state_d = BUSY;
                    md_d    = op[2] ? bMag : aMag;
                    lo_d    = op[2] ? aMag : bMag;
                end else begin
                    state_d  = DONE;
                    result_d = singleRes;
                    zero_d   = (singleRes == '0);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            md_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            md_q     <= md_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

endmodule
